// File: rtl/ix_scoreboard_pkg.sv
// Shared types for the issue stage: unit-class encodings, FSM states, unit select.
package ix_scoreboard_pkg;

  localparam logic [2:0] OT_INT    = 3'd0;
  localparam logic [2:0] OT_BRANCH = 3'd1;
  localparam logic [2:0] OT_LOAD   = 3'd2;
  localparam logic [2:0] OT_STORE  = 3'd3;
  localparam logic [2:0] OT_MULDIV = 3'd4;
  localparam logic [2:0] OT_CSR    = 3'd5;

  typedef enum logic [0:0] {
    ST_RUN   = 1'b0,
    ST_DRAIN = 1'b1
  } state_t;

  typedef enum logic [1:0] {
    UNIT_INT = 2'd0,
    UNIT_LSU = 2'd1,
    UNIT_MD  = 2'd2
  } unit_t;

endpackage

// File: rtl/ix_scoreboard_if.sv
// Decode-to-issue bundle: decoded instruction, three unit handshakes, writebacks, status.
interface ix_scoreboard_if #(
  parameter int CNT_W = 32
) ();
  logic             pipe_flush;
  logic             dec_ix_valid;
  logic             dec_ix_ready;
  logic [2:0]       dec_ix_op_type;
  logic             dec_ix_legal;
  logic             dec_ix_wb_en;
  logic [4:0]       dec_ix_rs1;
  logic [4:0]       dec_ix_rs2;
  logic [4:0]       dec_ix_rd;
  logic             dec_ix_fencei;
  logic             ix_int_valid;
  logic             ix_int_ready;
  logic             ix_lsu_valid;
  logic             ix_lsu_ready;
  logic             ix_md_valid;
  logic             ix_md_ready;
  logic             lsu_wb_valid;
  logic [4:0]       lsu_wb_rd;
  logic             md_wb_valid;
  logic [4:0]       md_wb_rd;
  logic             sb_busy;
  logic [CNT_W-1:0] ix_stall_cnt;

  modport slave (
    input  pipe_flush, dec_ix_valid, dec_ix_op_type, dec_ix_legal, dec_ix_wb_en,
           dec_ix_rs1, dec_ix_rs2, dec_ix_rd, dec_ix_fencei,
           ix_int_ready, ix_lsu_ready, ix_md_ready,
           lsu_wb_valid, lsu_wb_rd, md_wb_valid, md_wb_rd,
    output dec_ix_ready, ix_int_valid, ix_lsu_valid, ix_md_valid, sb_busy, ix_stall_cnt
  );

  modport master (
    output pipe_flush, dec_ix_valid, dec_ix_op_type, dec_ix_legal, dec_ix_wb_en,
           dec_ix_rs1, dec_ix_rs2, dec_ix_rd, dec_ix_fencei,
           ix_int_ready, ix_lsu_ready, ix_md_ready,
           lsu_wb_valid, lsu_wb_rd, md_wb_valid, md_wb_rd,
    input  dec_ix_ready, ix_int_valid, ix_lsu_valid, ix_md_valid, sb_busy, ix_stall_cnt
  );
endinterface

// File: rtl/ix_scoreboard_sb_regfile.sv
// 32x1 pending-write scoreboard: one set port, two clear ports, set beats clear, x0 never set.
module ix_scoreboard_sb_regfile (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_set_en,
  input  logic [4:0]  i_set_idx,
  input  logic        i_clr0_en,
  input  logic [4:0]  i_clr0_idx,
  input  logic        i_clr1_en,
  input  logic [4:0]  i_clr1_idx,
  output logic [31:0] o_sb
);

  logic [31:0] r_sb;
  logic [31:0] w_set;
  logic [31:0] w_clr;

  always_comb begin
    w_set = '0;
    w_clr = '0;
    if (i_set_en)  w_set[i_set_idx]  = 1'b1;
    if (i_clr0_en) w_clr[i_clr0_idx] = 1'b1;
    if (i_clr1_en) w_clr[i_clr1_idx] = 1'b1;
    w_set[0] = 1'b0;
  end

  // OR-ing the set mask after clearing gives set priority on the same index.
  always_ff @(posedge clk) begin
    if (!rst) r_sb <= '0;
    else      r_sb <= (r_sb & ~w_clr) | w_set;
  end

  assign o_sb = r_sb;

endmodule

// File: rtl/ix_scoreboard.sv
// Issue controller: routes decoded instructions to INT/LSU/MD, stalls on scoreboard hazards,
// drains outstanding writes before CSR/fence.i/illegal. Combinational issue, no buffering.
module ix_scoreboard
  import ix_scoreboard_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input logic           clk,
  input logic           rst,
  ix_scoreboard_if.slave ix
);

  state_t           r_state;
  logic [CNT_W-1:0] r_stall_cnt;
  logic [31:0]      w_sb;
  unit_t            w_target;
  logic             w_serial;
  logic             w_busy;
  logic             w_hz;
  logic             w_issue_ok;
  logic             w_tgt_rdy;
  logic             w_fire;
  logic             w_dec_rdy;
  logic             w_set_en;

  always_comb begin
    w_target = UNIT_INT;
    if (ix.dec_ix_legal && !ix.dec_ix_fencei) begin
      case (ix.dec_ix_op_type)
        OT_LOAD, OT_STORE: w_target = UNIT_LSU;
        OT_MULDIV:         w_target = UNIT_MD;
        default:           w_target = UNIT_INT;
      endcase
    end
  end

  assign w_serial = (ix.dec_ix_op_type == OT_CSR) || ix.dec_ix_fencei || !ix.dec_ix_legal;
  assign w_busy   = |w_sb;

  assign w_hz = (w_sb[ix.dec_ix_rs1] && (ix.dec_ix_rs1 != 5'd0)) ||
                (w_sb[ix.dec_ix_rs2] && (ix.dec_ix_rs2 != 5'd0)) ||
                (ix.dec_ix_wb_en && w_sb[ix.dec_ix_rd] && (ix.dec_ix_rd != 5'd0));

  // Reset gating keeps every unit valid low while reset is held.
  assign w_issue_ok = rst && ix.dec_ix_valid && !ix.pipe_flush && !w_hz && !(w_serial && w_busy);

  assign ix.ix_int_valid = w_issue_ok && (w_target == UNIT_INT);
  assign ix.ix_lsu_valid = w_issue_ok && (w_target == UNIT_LSU);
  assign ix.ix_md_valid  = w_issue_ok && (w_target == UNIT_MD);

  always_comb begin
    case (w_target)
      UNIT_LSU: w_tgt_rdy = ix.ix_lsu_ready;
      UNIT_MD:  w_tgt_rdy = ix.ix_md_ready;
      default:  w_tgt_rdy = ix.ix_int_ready;
    endcase
  end

  assign w_fire          = w_issue_ok && w_tgt_rdy;
  assign w_dec_rdy       = !ix.dec_ix_valid || ix.pipe_flush || w_fire;
  assign ix.dec_ix_ready = w_dec_rdy;

  // Only loads and mul/div produce late results; stores and INT ops are never tracked.
  assign w_set_en = w_fire && ix.dec_ix_wb_en &&
                    (((w_target == UNIT_LSU) && (ix.dec_ix_op_type == OT_LOAD)) ||
                     (w_target == UNIT_MD));

  ix_scoreboard_sb_regfile u_sb (
    .clk        (clk),
    .rst        (rst),
    .i_set_en   (w_set_en),
    .i_set_idx  (ix.dec_ix_rd),
    .i_clr0_en  (ix.lsu_wb_valid),
    .i_clr0_idx (ix.lsu_wb_rd),
    .i_clr1_en  (ix.md_wb_valid),
    .i_clr1_idx (ix.md_wb_rd),
    .o_sb       (w_sb)
  );

  assign ix.sb_busy      = w_busy;
  assign ix.ix_stall_cnt = r_stall_cnt;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state     <= ST_RUN;
      r_stall_cnt <= '0;
    end else begin
      case (r_state)
        ST_RUN:   if (ix.dec_ix_valid && !ix.pipe_flush && w_serial && w_busy) r_state <= ST_DRAIN;
        ST_DRAIN: if (ix.pipe_flush || w_fire) r_state <= ST_RUN;
        default:  r_state <= ST_RUN;
      endcase
      if (ix.dec_ix_valid && !w_dec_rdy && (r_stall_cnt != '1))
        r_stall_cnt <= r_stall_cnt + 1'b1;
    end
  end

endmodule
